// File: rtl/numbotron_pkg.sv
// Shared constants, per-counter op encoding and the mask-to-op helper for numbotron_regs.
package numbotron_pkg;

  localparam int NREGS = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2
  } op_e;

  // Opposing requests cancel, so inc and dec together behave like neither.
  function automatic op_e combine_op(input logic inc, input logic dec);
    op_e op;
    case ({inc, dec})
      2'b10:   op = OP_INC;
      2'b01:   op = OP_DEC;
      default: op = OP_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/numbotron_counter.sv
// One saturating-at-zero counter; increment at max wraps, or holds when NUMBOTRON_SAT_EN is defined.
import numbotron_pkg::*;

module numbotron_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] value_o,
  output logic             is_zero_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (value_q == {WIDTH{1'b1}});
  assign at_zero = (value_q == '0);

  always_comb begin
    value_d = value_q;
    case (op_i)
      OP_INC: begin
        if (at_max) begin
`ifdef NUMBOTRON_SAT_EN
          value_d = value_q;
`else
          value_d = '0;
`endif
        end else begin
          value_d = value_q + 1'b1;
        end
      end
      OP_DEC: begin
        if (!at_zero) value_d = value_q - 1'b1;
      end
      default: value_d = value_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value_o   = value_q;
  assign is_zero_o = at_zero;
  // Pulse only; the sticky flag lives in the parent.
  assign ovf_o     = (op_i == OP_INC) && at_max;

endmodule

// File: rtl/numbotron_regs.sv
// Bank of NREGS counters driven by program steps or edit buttons.
// Define NUMBOTRON_SAT_EN to saturate on increment at maximum instead of wrapping.
import numbotron_pkg::*;

module numbotron_regs #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 slowclk,
  input  logic                 running,
  input  logic                 dostep,
  input  logic [NREGS-1:0]     inc_regs,
  input  logic [NREGS-1:0]     dec_regs,
  input  logic [IDX_W-1:0]     edit_sel,
  input  logic                 edit_up,
  input  logic                 edit_down,
  output logic [NREGS-1:0]     reg_0,
  output logic [WIDTH-1:0]     disp_val,
  output logic                 overflow
);

  logic             up_q;
  logic             down_q;
  logic             overflow_q;
  logic             overflow_d;
  logic             step;
  logic             up_rise;
  logic             down_rise;
  op_e              edit_op;
  logic [NREGS-1:0] ovf_vec;
  logic [WIDTH-1:0] value_arr [NREGS];

  assign step      = slowclk & dostep & running;
  assign up_rise   = edit_up & ~up_q;
  assign down_rise = edit_down & ~down_q;
  assign edit_op   = combine_op(up_rise, down_rise);

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    op_e cnt_op;

    always_comb begin
      cnt_op = OP_HOLD;
      if (step)
        cnt_op = combine_op(inc_regs[gi], dec_regs[gi]);
      else if (!running && (edit_sel == IDX_W'(gi)))
        cnt_op = edit_op;
    end

    numbotron_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk_i     (clk),
      .srst_i    (rstb),
      .op_i      (cnt_op),
      .value_o   (value_arr[gi]),
      .is_zero_o (reg_0[gi]),
      .ovf_o     (ovf_vec[gi])
    );
  end

  assign overflow_d = overflow_q | (|ovf_vec);

  // Button history tracks continuously so a button held across a mode change gives no edge.
  always_ff @(posedge clk) begin
    if (rstb) begin
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      up_q       <= edit_up;
      down_q     <= edit_down;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
  assign disp_val = value_arr[edit_sel];

endmodule
